train_section_controller: RTL
=============================

// Module: train_section_controller
// PURPOSE
//  Parametrised successor to the 6-sensor train controller top level. Treats sensors as entry/exit
//  pairs bounding NUM_SECTIONS track sections. Debounces every sensor and keeps a per-section train
//  occupancy count. Drives stop signals and detects counting faults.
//  Shows per-section counts on the board's 4-digit multiplexed 7-segment display.
// PARAMETERS
//  NUM_SECTIONS  3   number of sections, legal 1..4; sensor count = 2*NUM_SECTIONS
//  DEB_CYCLES    4   consecutive equal synchronised samples needed to accept a sensor level (>=2)
//  CNT_W         2   width of each section occupancy counter (max count 2**CNT_W-1)
//  REFRESH_DIV   16  clk cycles each display digit stays enabled (>=2)
// PORTS
//  clk       in   1                 system clock, all logic on rising edge
//  rst_n     in   1                 asynchronous, active-low reset
//  sensors   in   2*NUM_SECTIONS    raw async sensors; bit 2k = entry of section k, bit 2k+1 = exit
//  err_clr   in   1                 sync pulse: clear all counts and faults
//  sig_stop  out  NUM_SECTIONS      1 = section k occupied or faulted, trains must hold before it
//  occ_flat  out  NUM_SECTIONS*CNT_W  count of section k at bits [k*CNT_W +: CNT_W]
//  err       out  NUM_SECTIONS      sticky fault flag per section
//  an        out  4                 digit enables, active-low
//  seg7      out  7                 segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset values: sig_stop=0, occ_flat=0, err=0, an=4'b1111, seg7=7'b1111111.
//  Reset clears sync flops, debounce state (level 0), counters, FSMs and the refresh divider.
//  Sensor input path:
//   - 2-FF synchroniser per sensor, then debounce.
//   - Debounced level changes only after DEB_CYCLES consecutive identical synchronised samples.
//   - Rising edge of the debounced level = 1-cycle event. Falling edges are ignored.
//   - Latency: a clean raw rise is sampled at edge 0; occ_flat/sig_stop update on edge 2+DEB_CYCLES+1.
//   - Glitches shorter than DEB_CYCLES cycles produce no event.
//  Per-section FSM with states FREE, OCCUPIED, FAULT:
//   - FREE: entry -> count=1, OCCUPIED. Exit -> FAULT (underflow), count stays 0.
//   - OCCUPIED, entry: count+1. At max it saturates and goes to FAULT (overflow).
//   - OCCUPIED, exit: count-1. When count reaches 0, go to FREE.
//   - Entry and exit events in the same cycle: count and state unchanged, no fault.
//   - FAULT: events ignored, count frozen, err=1, sig_stop forced 1. Only err_clr or reset exits.
//  Outputs:
//   - sig_stop[k] = (state != FREE).
//   - err[k] = (state == FAULT).
//  err_clr (all sections, next edge): count=0, state=FREE, err=0.
//   - err_clr wins over events arriving in the same cycle; those events are lost.
//   - Debounce state is not cleared.
//  Display:
//   - Refresh counter counts 0..REFRESH_DIV-1.
//   - Digit index advances 0->1->2->3->0 on each wrap.
//   - After reset the first digit (0) is enabled when the first wrap occurs.
//   - Digit i < NUM_SECTIONS: an bit i low, seg7 = hex glyph of count i, or 'E' if FAULT.
//   - Digit i >= NUM_SECTIONS: an=4'b1111 and seg7 blank for that slot.
//   - an and seg7 are registered and change on the same edge.
// STRUCTURE
//  Package train_pkg:
//   - localparams FREE=2'd0, OCCUPIED=2'd1, FAULT=2'd2.
//   - SEG_BLANK, SEG_E, and function hex_to_seg7(4-bit) -> 7-bit active-low glyph.
//  Sub-module sensor_debounce:
//   - Params DEB_CYCLES. Ports clk, rst_n, raw, level, rise.
//   - Contains the synchroniser, the debounce counter and the edge detector.
//   - Generated once per sensor.
//  Top block holds the section FSMs/counters (generate loop) and the display mux/refresh logic.
// TESTING
//  1. Entry S0 high 10 cycles: count0=1 and sig_stop[0]=1 on edge 2+DEB_CYCLES+1.
//     Then exit S1 high 10 cycles: count0=0, sig_stop[0]=0.
//  2. Glitch on S0 high DEB_CYCLES-1 cycles: no change to occ_flat, sig_stop or err.
//  3. S2 and S3 rise on the same cycle with section1 count=1: count stays 1, err[1]=0.
//  4. Exit S5 with section2 FREE: err[2]=1, sig_stop[2]=1, digit 2 shows 'E'.
//     Later entries on S4 are ignored. Pulse err_clr: err=0, count=0, state FREE.
//  5. CNT_W=2: four entries on S0: count saturates at 3, err[0]=1.
//  6. Display: counts {2,1,0}. Expect an to cycle 1110,1101,1011,1111, REFRESH_DIV cycles each.
//     Expect seg7 to show glyphs 2,1,0,blank. Assert rst_n mid-frame: all outputs return to reset values.

Source files
------------

// File: rtl/train_pkg.sv
// Shared constants for the track section controller: section states and
// active-low 7-segment glyphs {g,f,e,d,c,b,a}.
package train_pkg;

    localparam logic [1:0] FREE     = 2'd0;
    localparam logic [1:0] OCCUPIED = 2'd1;
    localparam logic [1:0] FAULT    = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;

    function automatic logic [6:0] hex_to_seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/train_section_controller_debounce.sv
// One sensor channel: 2-FF synchroniser, debounce counter and a registered
// single-cycle rising-edge event on the accepted level.
module sensor_debounce
    import train_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_level_d;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_s1      <= raw;
            r_s2      <= r_s1;
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
            // Any sample agreeing with the held level restarts the run.
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/train_section_controller.sv
// Track section occupancy controller: per-section counting FSMs fed by
// debounced entry/exit sensors, plus a multiplexed 4-digit count display.
module train_section_controller
    import train_pkg::*;
#(
    parameter int NUM_SECTIONS = 3,
    parameter int DEB_CYCLES   = 4,
    parameter int CNT_W        = 2,
    parameter int REFRESH_DIV  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2*NUM_SECTIONS-1:0]     sensors,
    input  logic                          err_clr,
    output logic [NUM_SECTIONS-1:0]       sig_stop,
    output logic [NUM_SECTIONS*CNT_W-1:0] occ_flat,
    output logic [NUM_SECTIONS-1:0]       err,
    output logic [3:0]                    an,
    output logic [6:0]                    seg7
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    logic [2*NUM_SECTIONS-1:0] w_level;
    logic [2*NUM_SECTIONS-1:0] w_rise;
    logic [6:0]                w_glyph [4];
    logic [3:0]                w_an    [4];

    for (genvar s = 0; s < 2*NUM_SECTIONS; s++) begin : g_sens
        sensor_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (sensors[s]),
            .level(w_level[s]),
            .rise (w_rise[s])
        );
    end

    for (genvar k = 0; k < NUM_SECTIONS; k++) begin : g_sec
        logic [1:0]       r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             w_in;
        logic             w_out;

        assign w_in  = w_rise[2*k]   & w_level[2*k];
        assign w_out = w_rise[2*k+1] & w_level[2*k+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= FREE;
                r_cnt   <= '0;
            end else if (err_clr) begin
                r_state <= FREE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    FREE: begin
                        if (w_in && !w_out) begin
                            r_cnt   <= CNT_ONE;
                            r_state <= OCCUPIED;
                        end else if (w_out && !w_in) begin
                            r_state <= FAULT;
                        end
                    end
                    OCCUPIED: begin
                        if (w_in && !w_out) begin
                            if (r_cnt == CNT_MAX) r_state <= FAULT;
                            else                  r_cnt   <= r_cnt + 1'b1;
                        end else if (w_out && !w_in) begin
                            r_cnt <= r_cnt - 1'b1;
                            if (r_cnt == CNT_ONE) r_state <= FREE;
                        end
                    end
                    FAULT:   r_state <= FAULT;
                    default: r_state <= FAULT;
                endcase
            end
        end

        assign sig_stop[k]                 = (r_state != FREE);
        assign err[k]                      = (r_state == FAULT);
        assign occ_flat[k*CNT_W +: CNT_W]  = r_cnt;
    end

    for (genvar i = 0; i < 4; i++) begin : g_dig
        if (i < NUM_SECTIONS) begin : g_on
            assign w_glyph[i] = (g_sec[i].r_state == FAULT) ? SEG_E
                              : hex_to_seg7(4'(g_sec[i].r_cnt));
            assign w_an[i]    = ~(4'b0001 << i);
        end else begin : g_off
            assign w_glyph[i] = SEG_BLANK;
            assign w_an[i]    = 4'b1111;
        end
    end

    logic [RW-1:0] r_ref;
    logic [1:0]    r_dig;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    // Each wrap latches the current digit then advances, so digit 0
    // appears on the first wrap after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref <= '0;
            r_dig <= 2'd0;
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
        end else if (r_ref == REF_LAST) begin
            r_ref <= '0;
            r_dig <= r_dig + 2'd1;
            r_an  <= w_an[r_dig];
            r_seg <= w_glyph[r_dig];
        end else begin
            r_ref <= r_ref + 1'b1;
        end
    end

    assign an   = r_an;
    assign seg7 = r_seg;

endmodule
